scan_mux_reg: RTL and testbench
===============================

Name: scan_mux_reg

Overview:
Parametrised, registered N-channel word multiplexer. It is the clocked successor to the team's 4:1 switch-level mux: any channel count, any data width, and a built-in channel sequencer. It selects one of CHANNELS input words, either directly from a select port or by auto-scanning with a programmable dwell. It feeds sampled-channel consumers, such as display scanners or a shared ADC/serialiser front end, that need a registered output tagged with its channel number.

Parameters:
WIDTH, 8, bits per channel word
CHANNELS, 4, number of input channels; must be >= 2
DWELL, 3, cycles spent on each channel in SCAN mode; must be >= 1
SEL_W, $clog2(CHANNELS), select/channel-index width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  global enable; 0 freezes all state
mode  input  2  00 DIRECT, 01 SCAN, 10 HOLD, 11 reserved (treated as HOLD)
sel_in  input  SEL_W  channel select in DIRECT mode; load value in SCAN mode
load_sel  input  1  SCAN only: jump to sel_in and restart dwell
data_in  input  CHANNELS*WIDTH  packed channel words; channel k is bits [k*WIDTH +: WIDTH]
out_data  output  WIDTH  registered selected word
out_ch  output  SEL_W  channel index that produced out_data
out_valid  output  1  out_data/out_ch updated this cycle
wrap  output  1  one-cycle pulse when a scan advances from channel CHANNELS-1 to 0
sel_err  output  1  one-cycle pulse when sel_in >= CHANNELS is presented for use

Behaviour:
- Reset (rst=1 at a clk edge): cur_sel=0, dwell_cnt=0, prev_mode=HOLD, out_data=0, out_ch=0, out_valid=0, wrap=0, sel_err=0. rst has priority over en and all other inputs.
- Latency: out_data and out_ch are the values of data_in[cur_sel] and cur_sel sampled at the edge, so outputs lag the select by 1 cycle. out_valid=1 on every enabled cycle after reset.
- en=0: cur_sel, dwell_cnt, out_data and out_ch hold; out_valid, wrap and sel_err are driven 0.
- DIRECT: cur_sel <= sel_in each enabled cycle. If sel_in >= CHANNELS, cur_sel holds and sel_err pulses. dwell_cnt is held at 0.
- SCAN:
  - dwell_cnt counts 0..DWELL-1.
  - When dwell_cnt==DWELL-1: dwell_cnt <= 0 and cur_sel <= cur_sel+1, wrapping CHANNELS-1 to 0. On the wrap, wrap=1 in the same cycle as the cur_sel update.
  - DWELL=1 advances every cycle.
- load_sel=1 in SCAN: cur_sel <= sel_in and dwell_cnt <= 0. load_sel has priority over a simultaneous advance, and no wrap pulse is generated. An out-of-range sel_in is ignored (normal advance proceeds) and sel_err pulses.
- load_sel has no effect outside SCAN.
- HOLD and mode 11: cur_sel and dwell_cnt are frozen; outputs keep tracking data_in[cur_sel] (data is live, channel is frozen).
- Mode change: on the first enabled cycle where mode differs from prev_mode, dwell_cnt <= 0. Entering SCAN starts from the current cur_sel, with a full dwell on that channel.
- Non-power-of-2 CHANNELS: the wrap compare is against CHANNELS-1, never the natural SEL_W rollover. Unused select codes are never reached internally.
- Reset mid-scan: all state returns to the reset values; the scan restarts at channel 0 when SCAN is next active.

Decomposition:
- Shared package (mux_pkg):
  - mode enum (MODE_DIRECT, MODE_SCAN, MODE_HOLD, MODE_RSVD), 2-bit.
  - Helper function for the packed-slice select.
- Sub-module: scan_seq. It contains the dwell counter, cur_sel register, wrap and load logic, and prev_mode tracking, and outputs cur_sel, wrap and sel_err.
- The top level holds the output register stage and the enable/valid logic.

Test Plan:
1. Defaults; reset; mode=SCAN, en=1, data_in words {0x44,0x33,0x22,0x11} for ch3..0 -> out_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. out_data matches 0x11.. per channel. wrap pulses exactly once, on the 3->0 advance.
2. DIRECT with sel_in=2 then 3 on consecutive cycles -> out_data=0x33 then 0x44, each 1 cycle after the select. sel_err stays 0.
3. CHANNELS=5, DIRECT, sel_in=6 -> sel_err=1 for 1 cycle and out_ch unchanged. SCAN run -> out_ch wraps 4->0 and never reaches 5..7.
4. SCAN at ch1 with dwell_cnt=2, load_sel=1, sel_in=3 on the same cycle -> cur_sel=3, dwell_cnt=0, no wrap pulse; then 3 cycles on ch3 followed by a wrap to 0.
5. SCAN, switch to HOLD on ch2 for 5 cycles while data_in[ch2] changes 0x22->0x5A -> out_ch stays 2 and out_data follows to 0x5A. Return to SCAN -> a full 3-cycle dwell on ch2.
6. en=0 for 4 cycles mid-scan -> outputs frozen and out_valid=0. Then rst=1 with en=1 -> all outputs 0 next cycle, and the scan resumes from ch0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered scanning channel multiplexer.
package mux_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  // The reserved code behaves exactly like HOLD, so fold it before any compare.
  function automatic mode_e norm_mode(input logic [1:0] raw);
    return (raw == MODE_RSVD) ? MODE_HOLD : mode_e'(raw);
  endfunction

  // LSB position of channel idx inside a packed bus of width-bit words.
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/scan_seq.sv
// Channel sequencer: current select, dwell counter, load/wrap handling and
// mode-change tracking for scan_mux_reg.
module scan_seq
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DWELL    = 3,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             load_sel,
  output logic [SEL_W-1:0] cur_sel,
  output logic             wrap,
  output logic             sel_err
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
  localparam logic [DW_W-1:0]  LAST_DW = DW_W'(DWELL - 1);

  logic [DW_W-1:0]  dwell_cnt, dwell_nxt, dwell_eff;
  logic [SEL_W-1:0] sel_nxt;
  mode_e            prev_mode, cur_mode;
  logic             mode_change, sel_ok, at_end, wrap_nxt, err_nxt;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    cur_mode    = norm_mode(mode);
    mode_change = (cur_mode != prev_mode);
    sel_ok      = (sel_in <= LAST_CH);
    // A mode change restarts the dwell, and that entry cycle is slot 0 of it,
    // so a freshly entered SCAN gives the current channel exactly DWELL cycles.
    dwell_eff   = mode_change ? '0 : dwell_cnt;
    at_end      = (dwell_eff == LAST_DW);
    sel_nxt     = cur_sel;
    dwell_nxt   = dwell_cnt;
    wrap_nxt    = 1'b0;
    err_nxt     = 1'b0;

    unique case (cur_mode)
      MODE_DIRECT: begin
        dwell_nxt = '0;
        if (sel_ok) sel_nxt = sel_in;
        else        err_nxt = 1'b1;
      end
      MODE_SCAN: begin
        if (load_sel && sel_ok) begin
          sel_nxt   = sel_in;
          dwell_nxt = '0;
        end else begin
          err_nxt = load_sel;
          if (at_end) begin
            dwell_nxt = '0;
            // Compare against the last real channel, not the SEL_W rollover.
            if (cur_sel == LAST_CH) begin
              sel_nxt  = '0;
              wrap_nxt = 1'b1;
            end else begin
              sel_nxt = cur_sel + SEL_W'(1);
            end
          end else begin
            dwell_nxt = dwell_eff + DW_W'(1);
          end
        end
      end
      default: begin
        if (mode_change) dwell_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel   <= '0;
      dwell_cnt <= '0;
      prev_mode <= MODE_HOLD;
      wrap      <= 1'b0;
      sel_err   <= 1'b0;
    end else if (en) begin
      cur_sel   <= sel_nxt;
      dwell_cnt <= dwell_nxt;
      prev_mode <= cur_mode;
      wrap      <= wrap_nxt;
      sel_err   <= err_nxt;
    end else begin
      wrap    <= 1'b0;
      sel_err <= 1'b0;
    end
  end

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N-channel word multiplexer with direct select, auto-scan and hold;
// the output word is tagged with the channel that produced it.
module scan_mux_reg
  import mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 3,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      load_sel,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  output logic                      wrap,
  output logic                      sel_err
);

  logic [SEL_W-1:0] cur_sel;
  logic [WIDTH-1:0] sel_word;

  scan_seq #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .sel_in   (sel_in),
    .load_sel (load_sel),
    .cur_sel  (cur_sel),
    .wrap     (wrap),
    .sel_err  (sel_err)
  );

  // cur_sel never leaves 0..CHANNELS-1, so the slice is always in range.
  assign sel_word = data_in[slice_lsb(int'(cur_sel), WIDTH) +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_data  <= sel_word;
      out_ch    <= cur_sel;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_mux_reg.sv
// Self-checking bench for scan_mux_reg: table-driven vectors run through an
// expected-result queue, on a 4-channel and a 5-channel instance.
module tb_scan_mux_reg;

  localparam logic [1:0] D = 2'b00, S = 2'b01, H = 2'b10, R = 2'b11;

  typedef struct {
    logic       rst, en;
    logic [1:0] mode;
    logic [2:0] sel;
    logic       load;
    logic [7:0] ch2;
    logic [7:0] e_data;
    logic [2:0] e_ch;
    logic       e_valid, e_wrap, e_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        rst4 = 1'b0, en4 = 1'b0, load4 = 1'b0;
  logic [1:0]  mode4 = H, sel4 = '0;
  logic [31:0] data4 = 32'h44332211;
  logic [7:0]  odata4;
  logic [1:0]  och4;
  logic        ovalid4, wrap4, err4;

  // 5-channel instance
  logic        rst5 = 1'b0, en5 = 1'b0, load5 = 1'b0;
  logic [1:0]  mode5 = H;
  logic [2:0]  sel5 = '0;
  logic [39:0] data5 = 40'h5544332211;
  logic [7:0]  odata5;
  logic [2:0]  och5;
  logic        ovalid5, wrap5, err5;

  scan_mux_reg #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .mode(mode4), .sel_in(sel4), .load_sel(load4),
    .data_in(data4), .out_data(odata4), .out_ch(och4), .out_valid(ovalid4),
    .wrap(wrap4), .sel_err(err4)
  );

  scan_mux_reg #(.WIDTH(8), .CHANNELS(5), .DWELL(3)) dut5 (
    .clk(clk), .rst(rst5), .en(en5), .mode(mode5), .sel_in(sel5), .load_sel(load5),
    .data_in(data5), .out_data(odata5), .out_ch(och5), .out_valid(ovalid5),
    .wrap(wrap5), .sel_err(err5)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t exp_q[$];
  vec_t t4[$];
  vec_t t5[$];

  function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                              input logic [2:0] s, input logic l, input logic [7:0] c2,
                              input logic [7:0] d, input logic [2:0] ch,
                              input logic vl, input logic w, input logic er);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.sel = s; v.load = l; v.ch2 = c2;
    v.e_data = d; v.e_ch = ch; v.e_valid = vl; v.e_wrap = w; v.e_err = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Drive one vector, queue its expected outputs, then compare after the edge.
  task automatic apply(input bit big, input int idx, input vec_t v);
    vec_t e;
    logic [7:0] a_data;
    logic [2:0] a_ch;
    logic a_valid, a_wrap, a_err;
    string tag;
    if (!big) begin
      rst4 = v.rst; en4 = v.en; mode4 = v.mode; sel4 = v.sel[1:0]; load4 = v.load;
      data4 = {8'h44, v.ch2, 8'h22, 8'h11};
    end else begin
      rst5 = v.rst; en5 = v.en; mode5 = v.mode; sel5 = v.sel; load5 = v.load;
    end
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (!big) begin
      a_data = odata4; a_ch = {1'b0, och4}; a_valid = ovalid4; a_wrap = wrap4; a_err = err4;
    end else begin
      a_data = odata5; a_ch = och5; a_valid = ovalid5; a_wrap = wrap5; a_err = err5;
    end
    tag = $sformatf("ch%0d[%0d]", big ? 5 : 4, idx);
    check({tag, " out_data"}, a_data, e.e_data);
    check({tag, " out_ch"}, {5'd0, a_ch}, {5'd0, e.e_ch});
    check({tag, " out_valid"}, {7'd0, a_valid}, {7'd0, e.e_valid});
    check({tag, " wrap"}, {7'd0, a_wrap}, {7'd0, e.e_wrap});
    check({tag, " sel_err"}, {7'd0, a_err}, {7'd0, e.e_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, then a full scan from ch0 with a 3-cycle dwell and one wrap.
    t4.push_back(mk(1, 0, H, 0, 0, 8'h33, 8'h00, 0, 0, 0, 0));
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 3; k++)
        t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h11 * (c + 1), 3'(c), 1, (c == 3 && k == 2), 0));
    t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h11, 0, 1, 0, 0));
    // DIRECT: output follows the select one cycle later; load_sel ignored.
    t4.push_back(mk(0, 1, D, 2, 0, 8'h33, 8'h11, 0, 1, 0, 0));
    t4.push_back(mk(0, 1, D, 3, 0, 8'h33, 8'h33, 2, 1, 0, 0));
    t4.push_back(mk(0, 1, D, 3, 1, 8'h33, 8'h44, 3, 1, 0, 0));
    // Load on the advance cycle of ch1 jumps to ch3 with no wrap.
    t4.push_back(mk(0, 1, D, 1, 0, 8'h33, 8'h44, 3, 1, 0, 0));
    t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h22, 1, 1, 0, 0));
    t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h22, 1, 1, 0, 0));
    t4.push_back(mk(0, 1, S, 3, 1, 8'h33, 8'h22, 1, 1, 0, 0));
    t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h44, 3, 1, 0, 0));
    t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h44, 3, 1, 0, 0));
    t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h44, 3, 1, 1, 0));
    t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h11, 0, 1, 0, 0));
    // Scan on to ch2, HOLD there while ch2 data changes, then resume SCAN.
    t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h11, 0, 1, 0, 0));
    t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h11, 0, 1, 0, 0));
    for (int k = 0; k < 3; k++)
      t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h22, 1, 1, 0, 0));
    t4.push_back(mk(0, 1, H, 0, 0, 8'h33, 8'h33, 2, 1, 0, 0));
    t4.push_back(mk(0, 1, H, 0, 1, 8'h33, 8'h33, 2, 1, 0, 0));
    t4.push_back(mk(0, 1, H, 0, 0, 8'h5A, 8'h5A, 2, 1, 0, 0));
    t4.push_back(mk(0, 1, R, 0, 0, 8'h5A, 8'h5A, 2, 1, 0, 0));
    t4.push_back(mk(0, 1, R, 1, 1, 8'h5A, 8'h5A, 2, 1, 0, 0));
    for (int k = 0; k < 3; k++)
      t4.push_back(mk(0, 1, S, 0, 0, 8'h5A, 8'h5A, 2, 1, 0, 0));
    t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h44, 3, 1, 0, 0));
    // en=0 freezes everything, then one enabled step, then reset mid-scan.
    for (int k = 0; k < 4; k++)
      t4.push_back(mk(0, 0, S, 0, 0, 8'h33, 8'h44, 3, 0, 0, 0));
    t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h44, 3, 1, 0, 0));
    t4.push_back(mk(1, 1, S, 2, 1, 8'h33, 8'h00, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h11, 0, 1, 0, 0));
    t4.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h22, 1, 1, 0, 0));

    // Five channels: out-of-range selects, and a wrap at ch4.
    t5.push_back(mk(1, 0, H, 0, 0, 8'h33, 8'h00, 0, 0, 0, 0));
    t5.push_back(mk(0, 1, D, 2, 0, 8'h33, 8'h11, 0, 1, 0, 0));
    t5.push_back(mk(0, 1, D, 6, 0, 8'h33, 8'h33, 2, 1, 0, 1));
    t5.push_back(mk(0, 1, D, 2, 0, 8'h33, 8'h33, 2, 1, 0, 0));
    for (int c = 2; c < 5; c++)
      for (int k = 0; k < 3; k++)
        t5.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h11 * (c + 1), 3'(c), 1, (c == 4 && k == 2), 0));
    t5.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h11, 0, 1, 0, 0));
    t5.push_back(mk(0, 1, S, 7, 1, 8'h33, 8'h11, 0, 1, 0, 1));
    t5.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h11, 0, 1, 0, 0));
    t5.push_back(mk(0, 1, S, 0, 0, 8'h33, 8'h22, 1, 1, 0, 0));

    for (int i = 0; i < t4.size(); i++) apply(1'b0, i, t4[i]);
    en4 = 1'b0;
    for (int i = 0; i < t5.size(); i++) apply(1'b1, i, t5[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
